count_bank: RTL and testbench

- Parametrised bank of CHANNELS up/down counters, each WIDTH bits, presented as one concatenated output bus.
- Next generation of the fixed-width 8/16-bit counters.
- Adds, per channel: enable, synchronous load, synchronous clear, wrap or saturate mode, terminal-count flag.
- Optional cascade mode chains all channels into a single CHANNELS*WIDTH counter.
- Sits beside the top-level counter wrapper and feeds status/display logic.

---
 rtl/count_bank_pkg.sv | 29 ++
 rtl/count_channel.sv | 53 +++++
 rtl/count_bank.sv | 63 ++++++
 tb/tb_count_bank.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/count_bank_pkg.sv
// rtl/count_bank_pkg.sv - shared constants and elaboration helpers for the counter bank
package count_bank_pkg;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    localparam int WIDTH_MIN    = 2;
    localparam int WIDTH_MAX    = 32;
    localparam int CHANNELS_MIN = 1;
    localparam int CHANNELS_MAX = 8;

    // Lowest bit of channel k inside a packed CHANNELS*WIDTH bus.
    function automatic int slice_lo(input int k, input int width);
        return k * width;
    endfunction

    // A saturating counter cannot produce a carry ripple, so cascade+saturate is rejected.
    function automatic bit params_legal(input int width, input int channels,
                                        input int saturate, input int cascade);
        bit ok;
        ok = 1'b1;
        if (width < WIDTH_MIN || width > WIDTH_MAX) ok = 1'b0;
        if (channels < CHANNELS_MIN || channels > CHANNELS_MAX) ok = 1'b0;
        if (saturate != MODE_WRAP && saturate != MODE_SAT) ok = 1'b0;
        if (cascade != 0 && saturate == MODE_SAT) ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/count_channel.sv
// rtl/count_channel.sv - one WIDTH-bit up/down counter with clear, load and terminal flag
module count_channel
    import count_bank_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int SATURATE = MODE_WRAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             step,
    input  logic             direction,
    output logic [WIDTH-1:0] count,
    output logic             terminal,
    output logic             carry_out
);

    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};

    logic at_bound;

    assign at_bound  = direction ? (count == MAX_VAL) : (count == '0);
    // Carry only ripples out of a genuine boundary step; clear/load win over stepping.
    assign carry_out = step & at_bound & ~clear & ~load;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count    <= '0;
            terminal <= 1'b0;
        end else if (clear) begin
            count    <= '0;
            terminal <= 1'b0;
        end else if (load) begin
            count    <= load_value;
            terminal <= 1'b0;
        end else if (step) begin
            terminal <= at_bound;
            if (at_bound && SATURATE == MODE_SAT) begin
                count <= count;
            end else if (direction) begin
                count <= count + ONE;
            end else begin
                count <= count - ONE;
            end
        end else begin
            terminal <= 1'b0;
        end
    end

endmodule

// File: rtl/count_bank.sv
// rtl/count_bank.sv - bank of up/down counters with optional cascade into one wide counter
module count_bank
    import count_bank_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 3,
    parameter int SATURATE = MODE_WRAP,
    parameter int CASCADE  = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       clear,
    input  logic [CHANNELS-1:0]       load,
    input  logic [CHANNELS*WIDTH-1:0] load_value,
    input  logic [CHANNELS-1:0]       enable,
    input  logic [CHANNELS-1:0]       direction,
    output logic [CHANNELS*WIDTH-1:0] count,
    output logic [CHANNELS-1:0]       terminal
);

    generate
        if (!params_legal(WIDTH, CHANNELS, SATURATE, CASCADE)) begin : g_illegal
            $error("count_bank: illegal parameters (WIDTH 2..32, CHANNELS 1..8, no CASCADE with SATURATE)");
        end
    endgenerate

    // A single channel has nothing to chain into, so it always runs independently.
    localparam bit CHAINED = (CASCADE != 0) && (CHANNELS > 1);

    logic [CHANNELS-1:0] step;
    logic [CHANNELS-1:0] carry;
    logic [CHANNELS-1:0] dir_eff;

    genvar k;
    generate
        for (k = 0; k < CHANNELS; k++) begin : g_chan
            if (CHAINED && k > 0) begin : g_casc
                assign step[k]    = enable[k] & carry[k-1];
                assign dir_eff[k] = direction[0];
            end else begin : g_indep
                assign step[k]    = enable[k];
                assign dir_eff[k] = direction[k];
            end

            count_channel #(
                .WIDTH    (WIDTH),
                .SATURATE (SATURATE)
            ) u_channel (
                .clk        (clk),
                .reset      (reset),
                .clear      (clear[k]),
                .load       (load[k]),
                .load_value (load_value[slice_lo(k, WIDTH) +: WIDTH]),
                .step       (step[k]),
                .direction  (dir_eff[k]),
                .count      (count[slice_lo(k, WIDTH) +: WIDTH]),
                .terminal   (terminal[k]),
                .carry_out  (carry[k])
            );
        end
    endgenerate

endmodule

// File: tb/tb_count_bank.sv
// tb/tb_count_bank.sv - scoreboard bench for count_bank in wrap, saturate and cascade builds
module tb_count_bank;

    localparam int W  = 8;
    localparam int C  = 3;
    localparam int BW = W * C;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [C-1:0]  i_clr, i_ld, i_en, i_dir;
    logic [BW-1:0] i_lv;
    logic [C-1:0]  c_clr, c_ld, c_en, c_dir;
    logic [BW-1:0] c_lv;

    logic [BW-1:0] w_count, s_count, c_count;
    logic [C-1:0]  w_term, s_term, c_term;

    count_bank #(.WIDTH(W), .CHANNELS(C), .SATURATE(0), .CASCADE(0)) u_wrap (
        .clk(clk), .reset(reset), .clear(i_clr), .load(i_ld), .load_value(i_lv),
        .enable(i_en), .direction(i_dir), .count(w_count), .terminal(w_term));

    count_bank #(.WIDTH(W), .CHANNELS(C), .SATURATE(1), .CASCADE(0)) u_sat (
        .clk(clk), .reset(reset), .clear(i_clr), .load(i_ld), .load_value(i_lv),
        .enable(i_en), .direction(i_dir), .count(s_count), .terminal(s_term));

    count_bank #(.WIDTH(W), .CHANNELS(C), .SATURATE(0), .CASCADE(1)) u_casc (
        .clk(clk), .reset(reset), .clear(c_clr), .load(c_ld), .load_value(c_lv),
        .enable(c_en), .direction(c_dir), .count(c_count), .terminal(c_term));

    typedef struct {
        logic [BW-1:0] w_cnt, s_cnt, c_cnt;
        logic [C-1:0]  w_t, s_t, c_t;
    } exp_t;

    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;

    int mw[C];
    int ms[C];
    int mc;

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Independent channel, reasoned as an integer in 0..255.
    function automatic int ch_next(input int v, input bit c, input bit l, input int lvv,
                                   input bit e, input bit d, input bit sat, output bit t);
        t = 1'b0;
        if (c) return 0;
        if (l) return lvv;
        if (!e) return v;
        if (d) begin
            if (v == 255) begin t = 1'b1; return sat ? 255 : 0; end
            return v + 1;
        end
        if (v == 0) begin t = 1'b1; return sat ? 0 : 255; end
        return v - 1;
    endfunction

    // Cascade bank seen as one 24-bit integer; a clear/load with enable always includes channel 0.
    function automatic int casc_next(input int v, input logic [C-1:0] clr, input logic [C-1:0] ld,
                                     input int lv, input logic [C-1:0] en, input bit d,
                                     output logic [C-1:0] t);
        int r;
        int mk;
        t = '0;
        if ((clr | ld) != 0) begin
            r = v;
            for (int k = 0; k < C; k++) begin
                if (clr[k])     r = r & ~(255 << (8 * k));
                else if (ld[k]) r = (r & ~(255 << (8 * k))) | (lv & (255 << (8 * k)));
            end
            return r;
        end
        if (en == 0) return v;
        for (int k = 0; k < C; k++) begin
            mk = (1 << (8 * (k + 1))) - 1;
            t[k] = d ? ((v & mk) == mk) : ((v & mk) == 0);
        end
        return d ? ((v + 1) & 32'hFFFFFF) : ((v - 1) & 32'hFFFFFF);
    endfunction

    task automatic apply(input logic [C-1:0] iclr, input logic [C-1:0] ild, input logic [BW-1:0] ilv,
                         input logic [C-1:0] ien, input logic [C-1:0] idir,
                         input logic [C-1:0] cclr, input logic [C-1:0] cld, input logic [BW-1:0] clv,
                         input logic [C-1:0] cen, input logic [C-1:0] cdir);
        exp_t e;
        bit tb;
        @(negedge clk);
        i_clr = iclr; i_ld = ild; i_lv = ilv; i_en = ien; i_dir = idir;
        c_clr = cclr; c_ld = cld; c_lv = clv; c_en = cen; c_dir = cdir;
        for (int k = 0; k < C; k++) begin
            mw[k] = ch_next(mw[k], iclr[k], ild[k], int'(ilv[8*k +: 8]), ien[k], idir[k], 1'b0, tb);
            e.w_t[k] = tb;
            ms[k] = ch_next(ms[k], iclr[k], ild[k], int'(ilv[8*k +: 8]), ien[k], idir[k], 1'b1, tb);
            e.s_t[k] = tb;
            e.w_cnt[8*k +: 8] = mw[k][7:0];
            e.s_cnt[8*k +: 8] = ms[k][7:0];
        end
        mc = casc_next(mc, cclr, cld, int'(clv), cen, cdir[0], e.c_t);
        e.c_cnt = mc[BW-1:0];
        sb.push_back(e);
    endtask

    task automatic indep(input logic [C-1:0] clr, input logic [C-1:0] ld, input logic [BW-1:0] lv,
                         input logic [C-1:0] en, input logic [C-1:0] dir);
        apply(clr, ld, lv, en, dir, '0, '0, '0, '0, '0);
    endtask

    task automatic casc(input logic [C-1:0] clr, input logic [C-1:0] ld, input logic [BW-1:0] lv,
                        input logic [C-1:0] en, input logic [C-1:0] dir);
        apply('0, '0, '0, '0, '0, clr, ld, lv, en, dir);
    endtask

    function automatic logic [7:0] pick();
        case ($urandom % 5)
            0: return 8'h00;
            1: return 8'h01;
            2: return 8'hFE;
            3: return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("wrap_count", w_count, e.w_cnt);
            check("wrap_term",  BW'(w_term), BW'(e.w_t));
            check("sat_count",  s_count, e.s_cnt);
            check("sat_term",   BW'(s_term), BW'(e.s_t));
            check("casc_count", c_count, e.c_cnt);
            check("casc_term",  BW'(c_term), BW'(e.c_t));
        end
    end

    initial begin
        logic [C-1:0]  r_clr, r_ld, r_en, r_dir, m;
        logic [BW-1:0] r_lv;
        int waited;

        i_clr = '0; i_ld = '0; i_lv = '0; i_en = '0; i_dir = '0;
        c_clr = '0; c_ld = '0; c_lv = '0; c_en = '0; c_dir = '0;
        for (int k = 0; k < C; k++) begin mw[k] = 0; ms[k] = 0; end
        mc = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Async reset mid-count with channel 0 at 0x37.
        apply('0, 3'b001, 24'h000036, '0, '0, '0, 3'b001, 24'h000036, '0, '0);
        apply('0, '0, '0, 3'b001, 3'b001, '0, '0, '0, 3'b111, 3'b001);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("rst_wrap_count", w_count, '0);
        check("rst_wrap_term",  BW'(w_term), '0);
        check("rst_sat_count",  s_count, '0);
        check("rst_casc_count", c_count, '0);
        check("rst_casc_term",  BW'(c_term), '0);
        i_en = '0; c_en = '0; i_dir = '0; c_dir = '0;
        for (int k = 0; k < C; k++) begin mw[k] = 0; ms[k] = 0; end
        mc = 0;
        @(negedge clk);
        reset = 1'b1;
        repeat (5) indep('0, '0, '0, '0, '0);

        // Wrap up on ch1 and down on ch2; saturation seen by the saturating build.
        indep('0, 3'b010, 24'h00FE00, '0, '0);
        repeat (3) indep('0, '0, '0, 3'b010, 3'b010);
        indep('0, 3'b100, 24'h010000, '0, '0);
        repeat (2) indep('0, '0, '0, 3'b100, 3'b000);
        indep('0, 3'b001, 24'h0000FD, '0, '0);
        repeat (5) indep('0, '0, '0, 3'b001, 3'b001);
        indep('0, '0, '0, 3'b001, 3'b000);

        // Priority clear > load > step, then load alone.
        indep(3'b001, 3'b001, 24'h000055, 3'b001, 3'b001);
        indep('0, 3'b001, 24'h000055, '0, '0);

        // Independent channels from 0x10 each.
        indep('0, 3'b111, 24'h101010, '0, '0);
        repeat (10) indep('0, '0, '0, 3'b011, 3'b001);

        // Cascade ripple up, load-suppressed carry, ripple down.
        casc('0, 3'b111, 24'h00FFFF, '0, '0);
        casc('0, '0, '0, 3'b111, 3'b001);
        casc('0, 3'b111, 24'h00FFFF, '0, '0);
        casc('0, 3'b001, 24'h000012, 3'b111, 3'b001);
        casc('0, 3'b111, 24'h000000, '0, '0);
        casc('0, '0, '0, 3'b111, 3'b110);
        casc('0, 3'b111, 24'hFFFFFF, '0, '0);
        casc('0, '0, '0, 3'b111, 3'b001);

        for (int n = 0; n < 300; n++) begin
            r_clr = ($urandom % 8 == 0) ? 3'($urandom) : '0;
            r_ld  = ($urandom % 5 == 0) ? 3'($urandom) : '0;
            r_lv  = {pick(), pick(), pick()};
            r_en  = 3'($urandom);
            r_dir = 3'($urandom);
            i_lv  = r_lv;
            apply(r_clr, r_ld, r_lv, r_en, r_dir,
                  '0, '0, '0, '0, '0);
            m = ($urandom % 6 == 0) ? 3'($urandom) : '0;
            if (m != 0) m[0] = 1'b1;
            r_en = ($urandom % 4 != 0) ? 3'b111 : 3'b000;
            r_lv = {pick(), pick(), pick()};
            if ($urandom % 2 == 0) begin
                casc(m, '0, r_lv, r_en, 3'($urandom));
            end else begin
                casc('0, m, r_lv, r_en, 3'($urandom));
            end
        end

        waited = 0;
        while (sb.size() > 0 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        check("scoreboard_drain", BW'(sb.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
